core_alu_serial: RTL and testbench
==================================

// Module: core_alu_serial
// PURPOSE
//  Parametrised, slice-serial successor to the core ALU. Executes one core_alu_ctl 13-bit control word on WIDTH-bit operands.
//  Processes SLICE bits per clock with a registered carry chain; NSLICE = WIDTH/SLICE cycles per op.
//  Sits between operand fetch and flag/register writeback; valid/ready on both sides; emits flag write-enables for the P-reg.
// PARAMETERS
//  WIDTH  8  operand/result width; >=2
//  SLICE  4  bits processed per RUN cycle; WIDTH % SLICE != 0 -> elaboration $error
// PORTS
//  clock        in   1      single clock, rising edge
//  reset        in   1      asynchronous, active-high
//  in_valid     in   1      operation offered
//  in_ready     out  1      op accepted on clock when in_valid & in_ready
//  in_control   in   13     control word (bit meanings below)
//  in_lhs       in   WIDTH  left operand
//  in_rhs       in   WIDTH  right operand
//  in_carry     in   1      current C flag
//  out_valid    out  1      result and flags valid
//  out_ready    in   1      consumer takes result when out_valid & out_ready
//  out_result   out  WIDTH  result
//  out_flags    out  4      {N,V,Z,C}
//  out_flags_we out  4      {N,V,Z,C} write enables
// BEHAVIOUR
//  Reset: state IDLE. in_ready=1; out_valid=0; out_result, out_flags, out_flags_we, all internal regs = 0. Reset mid-RUN/DONE aborts the op; no output.
//  FSM: IDLE --accept--> RUN (operands + control latched, slice cnt=0). RUN: one slice per clock; after NSLICE clocks -> DONE.
//       DONE --out_ready--> IDLE. in_ready = (state==IDLE) only.
//  Latency: out_valid rises exactly NSLICE edges after the accepting edge. Throughput: one op per NSLICE+2 clocks with out_ready=1.
//  Backpressure: while out_valid & !out_ready, every output is held stable. in_valid is ignored outside IDLE.
//  Control bits: b0 invert carry-out; b1 N,V from rhs[W-1],rhs[W-2]; b2 write N; b3 invert carry-in; b4 rhs=~rhs; b5 write C;
//   b6 force carry-in 0; b7 write V as add-overflow; b8 rhs=0 (before b4); b12 write Z; b11:9 select.
//  Effective: rhs_e = (b8?0:rhs) ^ {W{b4}}; cin = (b6?0:in_carry) ^ b3.
//  Select: 0 lhs; 1 rhs_e; 2 lhs+rhs_e+cin; 3 and; 4 or; 5 xor; 6 {lhs[W-2:0],cin}, cout=lhs[W-1]; 7 {cin,lhs[W-1:1]}, cout=lhs[0].
//  Slice order: LSB-first for selects 0-6; MSB-first for select 7. The registered chain carries the boundary bit between slices.
//  Carry out: C = cout ^ b0; cout=0 for selects 0,1,3,4,5.
//  Flags:
//   N = b1 ? rhs[W-1] : result[W-1].
//   V = b1 ? rhs[W-2] : ((lhs^res)&(rhs_e^res))[W-1].
//   Z = (result==0).
//  Write enables: weN=b2|b1; weV=b7|b1; weZ=b12; weC=b5 & select in {2,6,7}. Flags with we=0 are driven 0.
//  nop (all zero): passes lhs, all we=0, full normal latency.
//  SLICE==WIDTH: one RUN cycle.
//  Decimal mode is not supported. No wrap or overflow of the slice counter beyond NSLICE-1.
// TESTING
//  1 W8/S4 ctl=0x14A4 lhs=7F rhs=01 cin=0 -> after 2 RUN clocks: res=80, N1 V1 Z0 C0, we=1111.
//  2 ctl=0x154C (inc) lhs=FF -> res=00, Z1 N0, weC=0 weV=0.
//  3 ctl=0x1E64 (lsr) lhs=81 cin=1 -> res=40, C1 N0 Z0; checks MSB-first slice order.
//  4 ctl=0x1602 (bit) lhs=0F rhs=C0 -> res=00, Z1 N1 V1, weC=0.
//  5 Hold out_ready=0 for 5 clocks: outputs stable, in_ready=0. Assert reset mid-RUN: out_valid=0 and in_ready=1 after release.
//  6 W16/S4 ctl=0x14A4 lhs=00FF rhs=0001 cin=1 -> res=0101 after 4 RUN clocks, C0 V0 N0 Z0.

Source files
------------

// File: rtl/core_alu_serial.sv
// core_alu_serial
//   Slice-serial core ALU. It accepts one 13-bit control word with WIDTH-bit
//   operands and processes SLICE bits per clock. A registered chain bit (the
//   carry, or the bit shifted across a slice boundary) links the slices, so an
//   operation takes NSLICE = WIDTH/SLICE RUN cycles. The result, the {N,V,Z,C}
//   flags and the flag write-enables are held until the consumer takes them.
//
// Ports
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready     operation handshake (in_ready only in IDLE)
//   in_control              control word (carry, rhs and flag modifiers, select)
//   in_lhs, in_rhs          operands
//   in_carry                current C flag
//   out_valid / out_ready   result handshake
//   out_result              result
//   out_flags               {N,V,Z,C}; flags that are not written read as 0
//   out_flags_we            {N,V,Z,C} write enables
module core_alu_serial #(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [12:0]      in_control,
  input  logic [WIDTH-1:0] in_lhs,
  input  logic [WIDTH-1:0] in_rhs,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic [3:0]       out_flags_we
);

  if ((WIDTH < 2) || (SLICE < 1) || (WIDTH % SLICE != 0)) begin : g_bad_params
    $error("core_alu_serial: WIDTH must be >= 2 and a multiple of SLICE");
  end

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NSLICE - 1);
  localparam logic [WIDTH-1:0] SMASK = WIDTH'({SLICE{1'b1}});

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nx;

  logic [12:0]      ctl_q;
  logic [WIDTH-1:0] lhs_q;
  logic [WIDTH-1:0] rhs_q;      // effective rhs (zeroed / inverted at accept)
  logic [1:0]       rhs_top_q;  // raw rhs[W-1:W-2] for the BIT-style N/V
  logic [WIDTH-1:0] acc_q;
  logic             chain_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] in_rhs_e;
  logic             in_cin;
  logic [2:0]       sel;
  logic [CNT_W-1:0] sidx;
  int               off;
  logic [SLICE-1:0] lhs_sl;
  logic [SLICE-1:0] rhs_sl;
  logic [SLICE:0]   wide;
  logic [SLICE-1:0] slice_res;
  logic             chain_nx;
  logic [WIDTH-1:0] acc_nx;
  logic [7:0]       flag_nx;
  logic             last;

  // Flags and write enables from the finished result; returns {flags, we}.
  function automatic logic [7:0] flag_calc(
    input logic [12:0]      ctl,
    input logic [WIDTH-1:0] lhs,
    input logic [WIDTH-1:0] rhs_e,
    input logic [WIDTH-1:0] res,
    input logic [1:0]       rhs_top,
    input logic             cout
  );
    logic [WIDTH-1:0] ovf;
    logic [2:0]       fsel;
    logic             n, v, z, c;
    logic [3:0]       we;
    fsel = ctl[11:9];
    ovf  = (lhs ^ res) & (rhs_e ^ res);
    n    = ctl[1] ? rhs_top[1] : res[WIDTH-1];
    v    = ctl[1] ? rhs_top[0] : ovf[WIDTH-1];
    z    = (res == '0);
    c    = cout ^ ctl[0];
    we   = {ctl[2] | ctl[1], ctl[7] | ctl[1], ctl[12],
            ctl[5] & ((fsel == 3'd2) || (fsel == 3'd6) || (fsel == 3'd7))};
    return {({n, v, z, c} & we), we};
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign last      = (cnt_q == LAST);

  // Operand conditioning at accept: b8 zeroes rhs before b4 inverts it.
  always_comb begin
    in_rhs_e = (in_control[8] ? '0 : in_rhs) ^ {WIDTH{in_control[4]}};
    in_cin   = (in_control[6] ? 1'b0 : in_carry) ^ in_control[3];
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // One slice per RUN cycle. Rotate-right walks MSB-first so the bit that
  // crosses a slice boundary always comes from the slice already processed.
  always_comb begin
    sel       = ctl_q[11:9];
    sidx      = (sel == 3'd7) ? (LAST - cnt_q) : cnt_q;
    off       = int'(sidx) * SLICE;
    lhs_sl    = SLICE'(lhs_q >> off);
    rhs_sl    = SLICE'(rhs_q >> off);
    wide      = '0;
    slice_res = lhs_sl;
    chain_nx  = 1'b0;
    case (sel)
      3'd0: slice_res = lhs_sl;
      3'd1: slice_res = rhs_sl;
      3'd2: begin
        wide      = {1'b0, lhs_sl} + {1'b0, rhs_sl} + (SLICE+1)'(chain_q);
        slice_res = wide[SLICE-1:0];
        chain_nx  = wide[SLICE];
      end
      3'd3: slice_res = lhs_sl & rhs_sl;
      3'd4: slice_res = lhs_sl | rhs_sl;
      3'd5: slice_res = lhs_sl ^ rhs_sl;
      3'd6: begin
        wide      = {lhs_sl, chain_q};
        slice_res = wide[SLICE-1:0];
        chain_nx  = wide[SLICE];
      end
      default: begin
        wide      = {chain_q, lhs_sl};
        slice_res = wide[SLICE:1];
        chain_nx  = wide[0];
      end
    endcase
    acc_nx  = (acc_q & ~(SMASK << off)) | (WIDTH'(slice_res) << off);
    flag_nx = flag_calc(ctl_q, lhs_q, rhs_q, acc_nx, rhs_top_q, chain_nx);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctl_q        <= '0;
      lhs_q        <= '0;
      rhs_q        <= '0;
      rhs_top_q    <= '0;
      acc_q        <= '0;
      chain_q      <= 1'b0;
      cnt_q        <= '0;
      out_result   <= '0;
      out_flags    <= '0;
      out_flags_we <= '0;
    end else begin
      case (state)
        // accept: latch operands, seed the chain with the effective carry-in
        IDLE: begin
          if (in_valid) begin
            ctl_q     <= in_control;
            lhs_q     <= in_lhs;
            rhs_q     <= in_rhs_e;
            rhs_top_q <= in_rhs[WIDTH-1:WIDTH-2];
            acc_q     <= '0;
            chain_q   <= in_cin;
            cnt_q     <= '0;
          end
        end
        // slice step; the last slice publishes result and flags
        RUN: begin
          acc_q   <= acc_nx;
          chain_q <= chain_nx;
          if (last) begin
            out_result   <= acc_nx;
            out_flags    <= flag_nx[7:4];
            out_flags_we <= flag_nx[3:0];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_core_alu_serial.sv
// Testbench for core_alu_serial: four instances (W8/S4, W16/S4, W8/S8, W8/S1)
// share the stimulus; a selector routes the handshake to one at a time.
// Expected {result, flags, we} words go into a scoreboard queue when an
// operation is offered and are popped when the result is taken.
module tb_core_alu_serial;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [12:0] ctl = '0;
  logic [15:0] lhs = '0;
  logic [15:0] rhs = '0;
  logic        carry = 1'b0;
  int          which = 0;

  logic        rdy0, rdy1, rdy2, rdy3;
  logic        vld0, vld1, vld2, vld3;
  logic [7:0]  res0, res2, res3;
  logic [15:0] res1;
  logic [3:0]  fl0, fl1, fl2, fl3;
  logic [3:0]  we0, we1, we2, we3;

  logic        in_ready_m, out_valid_m;
  logic [15:0] res_m;
  logic [3:0]  flags_m, we_m;

  logic [23:0] sb[$];
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clock = ~clock;

  core_alu_serial #(.WIDTH(8), .SLICE(4)) dut0 (
    .clock(clock), .reset(reset), .in_valid(in_valid && which == 0), .in_ready(rdy0),
    .in_control(ctl), .in_lhs(lhs[7:0]), .in_rhs(rhs[7:0]), .in_carry(carry),
    .out_valid(vld0), .out_ready(out_ready), .out_result(res0),
    .out_flags(fl0), .out_flags_we(we0));

  core_alu_serial #(.WIDTH(16), .SLICE(4)) dut1 (
    .clock(clock), .reset(reset), .in_valid(in_valid && which == 1), .in_ready(rdy1),
    .in_control(ctl), .in_lhs(lhs), .in_rhs(rhs), .in_carry(carry),
    .out_valid(vld1), .out_ready(out_ready), .out_result(res1),
    .out_flags(fl1), .out_flags_we(we1));

  core_alu_serial #(.WIDTH(8), .SLICE(8)) dut2 (
    .clock(clock), .reset(reset), .in_valid(in_valid && which == 2), .in_ready(rdy2),
    .in_control(ctl), .in_lhs(lhs[7:0]), .in_rhs(rhs[7:0]), .in_carry(carry),
    .out_valid(vld2), .out_ready(out_ready), .out_result(res2),
    .out_flags(fl2), .out_flags_we(we2));

  core_alu_serial #(.WIDTH(8), .SLICE(1)) dut3 (
    .clock(clock), .reset(reset), .in_valid(in_valid && which == 3), .in_ready(rdy3),
    .in_control(ctl), .in_lhs(lhs[7:0]), .in_rhs(rhs[7:0]), .in_carry(carry),
    .out_valid(vld3), .out_ready(out_ready), .out_result(res3),
    .out_flags(fl3), .out_flags_we(we3));

  always_comb begin
    in_ready_m  = rdy0;
    out_valid_m = vld0;
    res_m       = {8'h00, res0};
    flags_m     = fl0;
    we_m        = we0;
    case (which)
      1: begin in_ready_m = rdy1; out_valid_m = vld1; res_m = res1;           flags_m = fl1; we_m = we1; end
      2: begin in_ready_m = rdy2; out_valid_m = vld2; res_m = {8'h00, res2}; flags_m = fl2; we_m = we2; end
      3: begin in_ready_m = rdy3; out_valid_m = vld3; res_m = {8'h00, res3}; flags_m = fl3; we_m = we3; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int width_of(input int k);
    return (k == 1) ? 16 : 8;
  endfunction

  function automatic int nslice_of(input int k);
    case (k)
      0: return 2;
      1: return 4;
      2: return 1;
      default: return 8;
    endcase
  endfunction

  // Whole-word reference: {result[15:0], flags{N,V,Z,C}, we{N,V,Z,C}}
  function automatic logic [23:0] model(input int w, input logic [12:0] c,
                                        input logic [15:0] l, input logic [15:0] r,
                                        input logic ci);
    logic [15:0] mask, re, res;
    logic [16:0] sum;
    logic        cn, cout, n, v, z, fc;
    logic [3:0]  we;
    logic [2:0]  s;
    mask = 16'((32'd1 << w) - 1);
    re   = ((c[8] ? 16'h0 : r) ^ (c[4] ? 16'hFFFF : 16'h0)) & mask;
    cn   = (c[6] ? 1'b0 : ci) ^ c[3];
    s    = c[11:9];
    cout = 1'b0;
    sum  = '0;
    case (s)
      3'd0: res = l;
      3'd1: res = re;
      3'd2: begin sum = {1'b0, l} + {1'b0, re} + {16'h0, cn}; res = sum[15:0]; cout = sum[w]; end
      3'd3: res = l & re;
      3'd4: res = l | re;
      3'd5: res = l ^ re;
      3'd6: begin res = (l << 1) | {15'h0, cn}; cout = l[w-1]; end
      default: begin res = (l >> 1) | (16'(cn) << (w - 1)); cout = l[0]; end
    endcase
    res = res & mask;
    n   = c[1] ? r[w-1] : res[w-1];
    v   = c[1] ? r[w-2] : ((l[w-1] ^ res[w-1]) & (re[w-1] ^ res[w-1]));
    z   = (res == 16'h0);
    fc  = cout ^ c[0];
    we  = {c[2] | c[1], c[7] | c[1], c[12], c[5] & (s == 3'd2 || s == 3'd6 || s == 3'd7)};
    return {res, ({n, v, z, fc} & we), we};
  endfunction

  // Offer one op, check latency, hold the result for 'hold' cycles, take it.
  task automatic run_op(input int k, input logic [12:0] c, input logic [15:0] l,
                        input logic [15:0] r, input logic ci, input logic [23:0] exp,
                        input int hold);
    int          n;
    logic [23:0] held, e;
    which    = k;
    ctl      = c;
    lhs      = l;
    rhs      = r;
    carry    = ci;
    in_valid = 1'b1;
    #1;
    check("accept_rdy", in_ready_m, 1);
    @(posedge clock); #1;
    sb.push_back(exp);
    // keep offering a different op while busy; it must be ignored
    ctl = 13'h1FFF;
    lhs = ~l;
    n   = 0;
    while (!out_valid_m && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    check("latency", n, nslice_of(k));
    check("busy_rdy", in_ready_m, 0);
    held = {res_m, flags_m, we_m};
    repeat (hold) begin
      @(posedge clock); #1;
      check("hold_out", {out_valid_m, res_m, flags_m, we_m}, {1'b1, held});
      check("hold_rdy", in_ready_m, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    e = sb.pop_front();
    check("result", res_m, e[23:8]);
    check("flags", flags_m, e[7:4]);
    check("flags_we", we_m, e[3:0]);
    @(posedge clock); #1;
    out_ready = 1'b0;
    check("idle_vld", out_valid_m, 0);
    check("idle_rdy", in_ready_m, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] rc;
    logic [15:0] rl, rr;
    logic        rci;
    int          rk;

    repeat (2) @(posedge clock);
    #1;
    for (int k = 0; k < 4; k++) begin
      which = k;
      #1;
      check("rst_rdy", in_ready_m, 1);
      check("rst_vld", out_valid_m, 0);
      check("rst_out", {res_m, flags_m, we_m}, 24'h0);
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;

    // add with overflow, increment, rotate right, bit test, nop
    run_op(0, 13'h14A4, 16'h007F, 16'h0001, 1'b0, 24'h0080CF, 0);
    run_op(0, 13'h154C, 16'h00FF, 16'h0000, 1'b0, 24'h00002A, 0);
    run_op(0, 13'h1E64, 16'h0081, 16'h0000, 1'b1, 24'h00401B, 0);
    run_op(0, 13'h1602, 16'h000F, 16'h00C0, 1'b0, 24'h0000EE, 0);
    run_op(0, 13'h0000, 16'h005A, 16'h00A5, 1'b1, 24'h005A00, 0);
    run_op(0, 13'h14A4, 16'h007F, 16'h0001, 1'b0, 24'h0080CF, 5);
    // wide operand, single slice, one-bit slices
    run_op(1, 13'h14A4, 16'h00FF, 16'h0001, 1'b1, 24'h01010F, 0);
    run_op(2, 13'h14A4, 16'h007F, 16'h0001, 1'b0, 24'h0080CF, 0);
    run_op(3, 13'h14A4, 16'h007F, 16'h0001, 1'b0, 24'h0080CF, 0);
    run_op(3, 13'h1E64, 16'h0081, 16'h0000, 1'b1, 24'h00401B, 2);

    for (int i = 0; i < 24; i++) begin
      rk  = $urandom_range(0, 3);
      rc  = 13'($urandom);
      rl  = 16'($urandom) & 16'((32'd1 << width_of(rk)) - 1);
      rr  = 16'($urandom) & 16'((32'd1 << width_of(rk)) - 1);
      rci = 1'($urandom);
      run_op(rk, rc, rl, rr, rci, model(width_of(rk), rc, rl, rr, rci), i % 3);
    end

    // reset in the middle of a RUN aborts the op
    which    = 1;
    ctl      = 13'h14A4;
    lhs      = 16'h1234;
    rhs      = 16'h4321;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    check("abort_vld", out_valid_m, 0);
    check("abort_rdy", in_ready_m, 1);
    @(negedge clock);
    reset = 1'b0;
    repeat (6) begin
      @(posedge clock); #1;
      check("post_abort_vld", out_valid_m, 0);
    end
    check("post_abort_rdy", in_ready_m, 1);
    check("post_abort_out", {res_m, flags_m, we_m}, 24'h0);
    run_op(1, 13'h14A4, 16'h00FF, 16'h0001, 1'b1, 24'h01010F, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
